tile_spawner: RTL and testbench
===============================

# tile_spawner

Sequential, parametrised tile spawner for the 2048 game datapath. It sits after the slide/merge stage. After each accepted move it places one new tile of value 2 or 4 into a uniformly chosen empty cell of an N×N board. It scans the board one cell per cycle, picks the target with a free-running LFSR, and signals completion or a full board with a one-cycle handshake.

## Interface
- `N`, default 4: board side; legal range 2..8.
- `W`, default 12: tile value width in bits.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a spawn; sampled only in IDLE.
- `matrix_in`, in, [W-1:0] × [N-1:0][N-1:0]: board to spawn into; sampled on the accepting edge only.
- `matrix_out`, out, [W-1:0] × [N-1:0][N-1:0]: registered board snapshot, including the new tile after `done`.
- `busy`, out, 1: high while in COUNT, PICK or PLACE.
- `done`, out, 1: one-cycle pulse when a request completes.
- `full`, out, 1: valid with `done`; 1 means no empty cell, so no tile was placed.
- `spawn_row`, out, $clog2(N): row of the placed tile; valid with `done`.
- `spawn_col`, out, $clog2(N): column of the placed tile; valid with `done`.

## Operation
- Cell linear index: p = row*N + col, with row-major scan order starting at 0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state.
  - Reloads `SEED` on `rst`.
- FSM states are IDLE, COUNT, PICK, PLACE and DONE.
- IDLE:
  - When `start`=1, copy `matrix_in` into the snapshot (`matrix_out`).
  - Clear the zero counter and scan index, then go to COUNT.
- COUNT:
  - Visit one cell per cycle; increment `zcnt` (width $clog2(N*N+1)) when the snapshot cell is 0.
  - After index N*N-1, go to PICK.
- PICK:
  - If `zcnt`==0, set `full`=1 and go to DONE.
  - Otherwise latch `target` = lfsr[15:0] mod `zcnt`.
  - Latch `val4` = (lfsr[2:0]==0), giving a 4 with probability 1/8.
  - Reset the scan index and zero rank, then go to PLACE.
- PLACE:
  - Visit one cell per cycle.
  - On a zero cell whose rank equals `target`: write `val4` ? 4 : 2 into that cell, record `spawn_row`/`spawn_col`, and go to DONE.
  - On a zero cell whose rank does not equal `target`: increment the rank.
  - A non-zero cell is left untouched.
- DONE: `done`=1 for this cycle only, `busy`=0, then return to IDLE.
- Exactly one cell changes per successful spawn; every other snapshot cell is bit-identical to `matrix_in`.
- `start` while `busy` is ignored and not queued.
- `matrix_in` changes after acceptance have no effect.
- `full`, `spawn_row` and `spawn_col` hold their values until the next accepted `start`, which clears `full`.
- Reset values:
  - FSM goes to IDLE.
  - `matrix_out` is all zeros.
  - `busy`, `done` and `full` are 0.
  - `spawn_row` and `spawn_col` are 0.
  - LFSR is `SEED`.
- `rst` asserted mid-operation aborts the request: no `done` and no partial write survive. It takes effect on the same edge.

## Timing
- Edge 0 samples `start`; cycle k below means the cycle after edge k-1.
- COUNT occupies cycles 1..N*N.
- PICK occupies cycle N*N+1.
- PLACE occupies cycles N*N+2 .. N*N+2+p, where p is the index of the chosen cell.
- `done` is high in cycle N*N+p+3.
- Full board: `done` is high in cycle N*N+2.
- Worst-case latency is 2*N*N+2 cycles.
- Back-to-back requests: the earliest next acceptance is the first IDLE cycle after DONE, i.e. `start` held high re-fires one cycle after `done`.
- `matrix_out` changes only on the accepting edge and on the PLACE write edge.

## Configuration
- `TILE_SPAWNER_FORCE_EN` defined adds two inputs:
  - `force_en` (1 bit).
  - `force_idx` ($clog2(N*N) bits).
- With `force_en`=1 sampled in PICK:
  - `target` = `force_idx` mod `zcnt`.
  - `val4` = `force_idx`[0], so odd gives 4 and even gives 2.
- Without the macro, those ports do not exist and the LFSR always decides.

## Test plan
- Reset with default parameters: all outputs zero and FSM in IDLE; hold `start`=1 during `rst` and confirm no request is accepted.
- FORCE, N=4, all-zero board, `force_idx`=5: cell (1,1)=4, all other cells 0, `spawn_row`=1, `spawn_col`=1, `done` in cycle 24, `full`=0.
- FORCE, N=4, zeros only at p=3,9,14, `force_idx`=2: cell (3,2)=2, `done` in cycle 33, all other cells unchanged.
- Full board, every cell 2: `done` and `full`=1 in cycle 18, `matrix_out` equals `matrix_in`.
- N=3, W=8, random mode, 200 spawns on random boards: exactly one previously-zero cell becomes 2 or 4, and `done` latency stays ≤ 2*9+2.
- Pulse `rst` in cycle 20 of a request: no `done`, `matrix_out` zero, and the next `start` completes normally.

Source files
------------

// File: rtl/tile_spawner.sv
// Spawns one 2/4 tile into a uniformly chosen empty cell of an N x N 2048 board.
// Optional macro TILE_SPAWNER_FORCE_EN adds force_en/force_idx to override the LFSR choice.
module tile_spawner #(
    parameter int          N    = 4,
    parameter int          W    = 12,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N-1:0][N-1:0][W-1:0]     matrix_in,
    output logic [N-1:0][N-1:0][W-1:0]     matrix_out,
    output logic                           busy,
    output logic                           done,
    output logic                           full,
    output logic [$clog2(N)-1:0]           spawn_row,
    output logic [$clog2(N)-1:0]           spawn_col
`ifdef TILE_SPAWNER_FORCE_EN
    ,
    input  logic                           force_en,
    input  logic [$clog2(N*N)-1:0]         force_idx
`endif
);

    // state  | meaning
    // IDLE   | waiting for start; snapshot and flags hold
    // COUNT  | one cell per cycle, counting empty cells
    // PICK   | choose target rank and tile value, or report full board
    // PLACE  | rescan, write tile into the empty cell of rank target
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_PICK, S_PLACE, S_DONE} state_t;

    localparam int RW = $clog2(N);
    localparam int ZW = $clog2(N*N + 1);

    state_t                       state_q;
    logic [N-1:0][N-1:0][W-1:0]   snap_q;
    logic [RW-1:0]                row_q, col_q, row_d, col_d;
    logic [RW-1:0]                srow_q, scol_q;
    logic [ZW-1:0]                zcnt_q, rank_q, target_q, target_d;
    logic                         val4_q, val4_d;
    logic                         busy_q, done_q, full_q;
    logic [15:0]                  lfsr_q, lfsr_d;
    logic                         cell_zero, last_cell;

    assign cell_zero = (snap_q[row_q][col_q] == '0);
    assign last_cell = (row_q == RW'(N-1)) && (col_q == RW'(N-1));
    assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        if (col_q == RW'(N-1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
        end else begin
            col_d = col_q + RW'(1);
            row_d = row_q;
        end
    end

    always_comb begin
        target_d = ZW'(lfsr_q % 16'(zcnt_q));
        val4_d   = (lfsr_q[2:0] == 3'b000);
`ifdef TILE_SPAWNER_FORCE_EN
        if (force_en) begin
            target_d = ZW'(16'(force_idx) % 16'(zcnt_q));
            val4_d   = force_idx[0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            snap_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            srow_q   <= '0;
            scol_q   <= '0;
            zcnt_q   <= '0;
            rank_q   <= '0;
            target_q <= '0;
            val4_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
            lfsr_q   <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_q  <= matrix_in;
                        row_q   <= '0;
                        col_q   <= '0;
                        zcnt_q  <= '0;
                        full_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (cell_zero) zcnt_q <= zcnt_q + ZW'(1);
                    if (last_cell) begin
                        state_q <= S_PICK;
                    end else begin
                        row_q <= row_d;
                        col_q <= col_d;
                    end
                end
                S_PICK: begin
                    if (zcnt_q == '0) begin
                        full_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        target_q <= target_d;
                        val4_q   <= val4_d;
                        row_q    <= '0;
                        col_q    <= '0;
                        rank_q   <= '0;
                        state_q  <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    // target < zcnt, so a matching empty cell is always found before the scan ends
                    if (cell_zero && rank_q == target_q) begin
                        snap_q[row_q][col_q] <= val4_q ? W'(4) : W'(2);
                        srow_q  <= row_q;
                        scol_q  <= col_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        if (cell_zero) rank_q <= rank_q + ZW'(1);
                        row_q <= row_d;
                        col_q <= col_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign matrix_out = snap_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign full       = full_q;
    assign spawn_row  = srow_q;
    assign spawn_col  = scol_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: vector table, hand sequences and randomized spawns
// against a queue-based reference model; force cases compile only with TILE_SPAWNER_FORCE_EN.
module tb_tile_spawner;

    localparam int          N    = 4;
    localparam int          W    = 12;
    localparam int          NN   = N * N;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef logic [N-1:0][N-1:0][W-1:0] board_t;

    logic                   clk = 1'b0;
    logic                   rst, start;
    board_t                 min, mout;
    logic                   busy, done, full;
    logic [$clog2(N)-1:0]   srow, scol;
`ifdef TILE_SPAWNER_FORCE_EN
    logic                   force_en;
    logic [$clog2(NN)-1:0]  force_idx;
`endif

    tile_spawner #(.N(N), .W(W), .SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .matrix_in  (min),
        .matrix_out (mout),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .spawn_row  (srow),
        .spawn_col  (scol)
`ifdef TILE_SPAWNER_FORCE_EN
        ,
        .force_en   (force_en),
        .force_idx  (force_idx)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // The 16-bit Galois LFSR as defined for the block, free-running from reset.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input board_t act, input board_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic board_t rand_board();
        board_t b;
        for (int p = 0; p < NN; p++)
            b[p/N][p%N] = ($urandom_range(0, 1) == 0) ? W'(0) : W'(1 << $urandom_range(1, 10));
        return b;
    endfunction

    // Reference: list the empty cells in scan order, pick one by rank.
    function automatic void model(input board_t b, input logic [15:0] l, input bit fe, input int fi,
                                  output board_t eb, output int ep, output bit ef);
        int zq[$];
        int t;
        bit v4;
        eb = b;
        ep = 0;
        ef = 0;
        for (int p = 0; p < NN; p++)
            if (b[p/N][p%N] == '0) zq.push_back(p);
        if (zq.size() == 0) begin
            ef = 1;
            return;
        end
        if (fe) begin
            t  = fi % zq.size();
            v4 = (fi % 2) == 1;
        end else begin
            t  = int'(l) % zq.size();
            v4 = (l[2:0] == 3'b000);
        end
        ep = zq[t];
        eb[ep/N][ep%N] = v4 ? W'(4) : W'(2);
    endfunction

    task automatic run_spawn(input board_t b, input bit fe, input int fi, input string tag);
        board_t      eb;
        int          ep, ecyc, k;
        bit          ef, got;
        logic [15:0] pick_l;
        @(negedge clk);
        min   = b;
        start = 1'b1;
`ifdef TILE_SPAWNER_FORCE_EN
        force_en  = fe;
        force_idx = ($clog2(NN))'(fi);
`endif
        @(negedge clk);
        start  = 1'b0;
        k      = 1;
        got    = 0;
        pick_l = '0;
        chk({tag, " busy_after_accept"}, busy, 1);
        while (k <= 2*NN + 8) begin
            if (k == NN + 1) pick_l = m_lfsr;
            if (done) begin
                got = 1;
                break;
            end
            // stray starts and a changing input board must not disturb the request
            min   = rand_board();
            start = $urandom_range(0, 1) == 1;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        model(b, pick_l, fe, fi, eb, ep, ef);
        ecyc = ef ? NN + 2 : NN + ep + 3;
        chk({tag, " done_cycle"}, got ? k : -1, ecyc);
        chk({tag, " latency_bound"}, (got && k <= 2*NN + 2) ? 1 : 0, 1);
        chk({tag, " full"}, full, ef);
        chk_b({tag, " board"}, mout, eb);
        if (!ef) begin
            chk({tag, " row"}, srow, ep / N);
            chk({tag, " col"}, scol, ep % N);
        end
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " busy_idle"}, busy, 0);
    endtask

    typedef struct {
        logic [NN-1:0] zmask;
        logic [W-1:0]  fillv;
        bit            exp_full;
    } vec_t;

    vec_t   tbl[6];
    board_t bb;
    int     seen_done;

    initial begin
        tbl[0] = '{16'hFFFF, 12'd2,    1'b0};
        tbl[1] = '{16'h0000, 12'd2,    1'b1};
        tbl[2] = '{16'h8000, 12'd8,    1'b0};
        tbl[3] = '{16'h0001, 12'd16,   1'b0};
        tbl[4] = '{16'h4208, 12'd8,    1'b0};
        tbl[5] = '{16'hAAAA, 12'd1024, 1'b0};

        start = 1'b1;
        rst   = 1'b1;
        min   = rand_board();
`ifdef TILE_SPAWNER_FORCE_EN
        force_en  = 1'b0;
        force_idx = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst full", full, 0);
        chk("rst row", srow, 0);
        chk("rst col", scol, 0);
        chk_b("rst board", mout, '0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst no_accept", busy, 0);

        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < NN; p++) bb[p/N][p%N] = tbl[i].zmask[p] ? W'(0) : tbl[i].fillv;
            run_spawn(bb, 0, 0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d table_full", i), full, tbl[i].exp_full);
            if (tbl[i].exp_full) chk_b($sformatf("vec%0d unchanged", i), mout, bb);
        end

`ifdef TILE_SPAWNER_FORCE_EN
        run_spawn('0, 1, 5, "force5");
        chk("force5 cell11", mout[1][1], 4);
        chk("force5 row", srow, 1);
        chk("force5 col", scol, 1);
        for (int p = 0; p < NN; p++) bb[p/N][p%N] = (p == 3 || p == 9 || p == 14) ? W'(0) : W'(32);
        run_spawn(bb, 1, 2, "force2");
        chk("force2 cell32", mout[3][2], 2);
        chk("force2 row", srow, 3);
        chk("force2 col", scol, 2);
        force_en = 1'b0;
`endif

        // abort with rst in cycle 20 of a long request
        for (int p = 0; p < NN; p++) bb[p/N][p%N] = (p >= 14) ? W'(0) : W'(2);
        @(negedge clk);
        min   = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (int k = 1; k < 20; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort full", full, 0);
        chk_b("abort board", mout, '0);
        for (int k = 0; k < 25; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        chk("abort no_done", seen_done, 0);
        run_spawn(bb, 0, 0, "after_abort");

        // start held high re-fires one cycle after done
        @(negedge clk);
        min   = '0;
        start = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 2*NN + 8 && !done; k++) @(negedge clk);
        chk("b2b first_done", done, 1);
        @(negedge clk);
        chk("b2b idle_gap", busy, 0);
        @(negedge clk);
        chk("b2b refire", busy, 1);
        start = 1'b0;
        for (int k = 0; k < 2*NN + 8 && !done; k++) @(negedge clk);
        chk("b2b second_done", done, 1);
        @(negedge clk);

        for (int i = 0; i < 200; i++) run_spawn(rand_board(), 0, 0, $sformatf("rnd%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
